// File: rtl/inst_fetch_if.sv
// Fetch-side bus bundle for inst_fetch.
//   stall / branch_flag_i / branch_target_address_i : control from IF/ID and ID
//   rom_ce_o / rom_addr_o / rom_data_i               : instruction ROM port
//   if_pc_o / if_inst_o / if_valid_o                 : instruction presented to IF/ID
// master = fetch unit, slave = surrounding SOPC (ROM + pipeline).
interface inst_fetch_if;
  logic        stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  modport master (
    input  stall, branch_flag_i, branch_target_address_i, rom_data_i,
    output rom_ce_o, rom_addr_o, if_pc_o, if_inst_o, if_valid_o
  );

  modport slave (
    output stall, branch_flag_i, branch_target_address_i, rom_data_i,
    input  rom_ce_o, rom_addr_o, if_pc_o, if_inst_o, if_valid_o
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, issues word reads to a
// one-cycle-latency ROM and buffers returned words in a 2-entry queue
// feeding IF/ID. Branch redirects from ID flush queued and in-flight fetches.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - inst_fetch_if.master (control in, ROM port, IF/ID outputs)
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  inst_fetch_if.master  bus
);

  localparam int unsigned AW    = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [AW-1:0]             pc, pc_n;
  logic [AW-1:0]             infl_pc, infl_pc_n;
  logic                      inflight, inflight_n;
  logic [CNT_W-1:0]          occ, occ_n, occ_p, room;
  logic [DEPTH-1:0][AW-1:0]  q_pc, q_pc_n;
  logic [DEPTH-1:0][AW-1:0]  q_inst, q_inst_n;
  logic                      pop, redirect, issue;

  // Handshake terms; stall reaches rom_ce_o combinationally so a pop frees
  // a slot for a new request in the same cycle.
  assign pop      = (occ != '0) & ~bus.stall;
  assign redirect = bus.branch_flag_i & ~bus.stall;
  assign room     = occ + CNT_W'(inflight) - CNT_W'(pop);
  assign issue    = ~rst & ~redirect & (room < CNT_W'(DEPTH));

  assign bus.rom_ce_o   = issue;
  assign bus.rom_addr_o = pc;
  assign bus.if_valid_o = (occ != '0);
  assign bus.if_pc_o    = q_pc[0];
  assign bus.if_inst_o  = q_inst[0];

  // Next-state: redirect flushes everything; otherwise shift on pop, then
  // append the returning ROM word behind whatever remains.
  always_comb begin
    pc_n       = pc;
    infl_pc_n  = infl_pc;
    inflight_n = inflight;
    occ_n      = occ;
    occ_p      = occ - CNT_W'(pop);
    q_pc_n     = q_pc;
    q_inst_n   = q_inst;

    if (redirect) begin
      pc_n       = bus.branch_target_address_i;
      inflight_n = 1'b0;
      occ_n      = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          q_pc_n[i]   = q_pc[i+1];
          q_inst_n[i] = q_inst[i+1];
        end
      end
      if (inflight) begin
        q_pc_n[occ_p[IDX_W-1:0]]   = infl_pc;
        q_inst_n[occ_p[IDX_W-1:0]] = bus.rom_data_i;
      end
      occ_n      = occ_p + CNT_W'(inflight);
      inflight_n = issue;
      if (issue) begin
        pc_n      = pc + AW'(4);
        infl_pc_n = pc;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      infl_pc  <= '0;
      inflight <= 1'b0;
      occ      <= '0;
      q_pc     <= '0;
      q_inst   <= '0;
    end else begin
      pc       <= pc_n;
      infl_pc  <= infl_pc_n;
      inflight <= inflight_n;
      occ      <= occ_n;
      q_pc     <= q_pc_n;
      q_inst   <= q_inst_n;
    end
  end

endmodule
